// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
// Digit-serial BCD adder. It adds two packed DIGITS-digit BCD operands and a
// carry-in, one decimal digit per clock, least-significant digit first.
// Each digit is added in binary and then corrected by +6.
// A start/busy/done handshake frames each operation.
//
// Handshake: start is sampled only while busy=0, which covers both IDLE and
// the DONE cycle. An accepted start raises busy on the next cycle for exactly
// DIGITS cycles. done then pulses for one cycle, and in that same cycle
// sum/cout/err take their new values. They hold those values until the next
// done pulse. A start seen while busy=1 is ignored.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     begin an addition (sampled when busy=0)
//   a, b      packed BCD operands; digit 0 sits in bits [3:0]
//   cin       decimal carry into digit 0
//   busy      high while digits are being processed
//   done      one-cycle completion pulse
//   sum       registered BCD result
//   cout      decimal carry out of the top digit
//   err       some operand digit was > 9 in the completed operation
//   dbg_state current FSM state (0 IDLE, 1 RUN, 2 DONE)
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err,
    output logic [1:0]            dbg_state
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    logic [1:0]       state_q,   state_d;
    logic [W-1:0]     a_sh_q,    a_sh_d;
    logic [W-1:0]     b_sh_q,    b_sh_d;
    logic [W-1:0]     acc_q,     acc_d;
    logic             carry_q,   carry_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             err_acc_q, err_acc_d;
    logic [W-1:0]     sum_q,     sum_d;
    logic             cout_q,    cout_d;
    logic             err_q,     err_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // Datapath for the digit currently at the bottom of the shift registers.
    logic [4:0]       z;
    logic [3:0]       digit;
    logic             digit_carry;
    logic             digit_bad;
    logic [W+3:0]     acc_shift;
    logic [W-1:0]     acc_next;

    always_comb begin
        z           = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0, carry_q};
        digit_carry = (z > 5'd9);
        // Adding 6 and keeping the low nibble gives (z + 6) mod 16.
        digit       = digit_carry ? (z[3:0] + 4'd6) : z[3:0];
        digit_bad   = (a_sh_q[3:0] > 4'd9) || (b_sh_q[3:0] > 4'd9);
        // Shift the new digit in at the top. Going through a wider vector
        // keeps this legal when DIGITS=1.
        acc_shift   = {digit, acc_q};
        acc_next    = acc_shift[W+3:4];
    end

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        err_acc_d = err_acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d    = a;
                    b_sh_d    = b;
                    acc_d     = '0;
                    carry_d   = cin;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                    state_d   = S_RUN;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d     = acc_next;
                a_sh_d    = a_sh_q >> 4;
                b_sh_d    = b_sh_q >> 4;
                carry_d   = digit_carry;
                err_acc_d = err_acc_q | digit_bad;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Publish the result on the same edge as the last digit.
                    sum_d   = acc_next;
                    cout_d  = digit_carry;
                    err_d   = err_acc_q | digit_bad;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // busy and done are registered copies of the next state, so every
        // output comes straight from a flop.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Testbench for bcd_serial_adder with DIGITS=4. It runs directed and random
// additions. Each result is compared with a decimal arithmetic reference:
// operands are converted to integers, added, then converted back to BCD.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10 ** DIGITS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    logic [1:0]   dbg_state;

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Driver and checker for one operation. It is entered at a negedge with
    // busy=0 and leaves at the negedge of the done cycle. With noise set,
    // start and the operands are churned during RUN; none of that may
    // affect the result.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input bit noise);
        logic [W-1:0] ps, es;
        logic pc, pe, ec, ee;
        int tot;
        ps = sum; pc = cout; pe = err;
        tot = bcd2int(oa) + bcd2int(ob) + int'(oc);
        ee  = has_bad(oa) | has_bad(ob);
        ec  = (tot >= MODV);
        exp_q.push_back(int2bcd(tot % MODV));
        a = oa; b = ob; cin = oc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (noise) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom);
            end
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("hold_sum", 32'(sum), 32'(ps));
            chk("hold_cout", 32'(cout), 32'(pc));
            chk("hold_err", 32'(err), 32'(pe));
            @(negedge clk);
        end
        start = 1'b0;
        es = exp_q.pop_front();
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("err", 32'(err), 32'(ee));
        // With invalid digits only err is defined.
        if (!ee) begin
            chk("sum", 32'(sum), 32'(es));
            chk("cout", 32'(cout), 32'(ec));
        end
    endtask

    task automatic idle(input int n);
        logic [W-1:0] ps;
        ps = sum;
        start = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sum", 32'(sum), 32'(ps));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Directed cases.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        idle(2);
        run_op(16'h0999, 16'h0001, 1'b0, 1'b0);
        idle(1);
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        // Back-to-back: the next start is issued in the done cycle.
        run_op(16'h5555, 16'h4444, 1'b1, 1'b0);
        idle(1);
        run_op(16'h12A4, 16'h0000, 1'b0, 1'b0);
        idle(1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        idle(1);

        // Abort with a one-cycle reset at k+2.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        idle(8);

        // start and operands churned during RUN must be ignored.
        run_op(16'h2468, 16'h1357, 1'b1, 1'b1);
        idle(3);

        // Random valid operands, with some back-to-back.
        for (int n = 0; n < 30; n++) begin
            run_op(rand_bcd(), rand_bcd(), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        // Random operands that may hold invalid digits; only err is checked.
        for (int n = 0; n < 10; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
